// File: rtl/addsub_pkg.sv
// ============================================================
// addsub_pkg : shared widths, word type and CLA group helper
// rev 1.0
// ============================================================
`default_nettype none

package addsub_pkg;

  localparam int ADDSUB_WIDTH = 8;
  localparam int CLA_GROUP    = 4;

  typedef logic [ADDSUB_WIDTH-1:0] word_t;

  // Lookahead carry into bit n of a group, expanded as a flat sum of products.
  function automatic logic grp_carry(input logic [CLA_GROUP-1:0] g,
                                     input logic [CLA_GROUP-1:0] p,
                                     input logic                 cin,
                                     input int                   n);
    logic c_acc;
    logic p_acc;
    c_acc = 1'b0;
    p_acc = 1'b1;
    for (int j = CLA_GROUP - 1; j >= 0; j--) begin
      if (j < n) begin
        c_acc = c_acc | (p_acc & g[j]);
        p_acc = p_acc & p[j];
      end
    end
    return c_acc | (p_acc & cin);
  endfunction

endpackage

`default_nettype wire

// File: rtl/addsub8_rca_core.sv
// ============================================================
// rca_core : parameterised ripple-carry adder (cross-check path)
// rev 1.0
// ============================================================
`default_nettype none

module rca_core
  import addsub_pkg::*;
#(
  parameter int WIDTH = ADDSUB_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  always_comb begin
    logic c_chain;
    sum     = '0;
    c_chain = cin;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i]  = a[i] ^ b[i] ^ c_chain;
      c_chain = (a[i] & b[i]) | (c_chain & (a[i] ^ b[i]));
    end
    cout = c_chain;
  end

endmodule

`default_nettype wire

// File: rtl/addsub8.sv
// ============================================================
// addsub8 : registered CLA add/sub with ripple-carry cross-check
// rev 1.0
// ============================================================
`default_nettype none

module addsub8
  import addsub_pkg::*;
#(
  parameter int WIDTH = ADDSUB_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic [WIDTH-1:0] y,
  output logic             carry,
  output logic             overflow,
  output logic             mismatch
);

  localparam int NG = WIDTH / CLA_GROUP;

  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH-1:0] w_g;
  logic [WIDTH-1:0] w_p;
  logic [NG-1:0]    w_gg;
  logic [NG-1:0]    w_gp;
  logic [NG:0]      w_cgrp;
  logic [WIDTH-1:0] w_cla_y;
  logic             w_cla_c;
  logic [WIDTH-1:0] w_rca_y;
  logic             w_rca_c;

  logic [WIDTH-1:0] y_d, y_q;
  logic             carry_d, carry_q;
  logic             overflow_d, overflow_q;
  logic             mismatch_d, mismatch_q;

  assign w_b_eff = b ^ {WIDTH{carry_in}};
  assign w_g     = a & w_b_eff;
  assign w_p     = a ^ w_b_eff;

  generate
    for (genvar k = 0; k < NG; k++) begin : g_group
      assign w_gg[k] = grp_carry(w_g[k*CLA_GROUP +: CLA_GROUP],
                                 w_p[k*CLA_GROUP +: CLA_GROUP], 1'b0, CLA_GROUP);
      assign w_gp[k] = &w_p[k*CLA_GROUP +: CLA_GROUP];
      for (genvar i = 0; i < CLA_GROUP; i++) begin : g_bit
        assign w_cla_y[k*CLA_GROUP + i] =
          w_p[k*CLA_GROUP + i] ^
          grp_carry(w_g[k*CLA_GROUP +: CLA_GROUP],
                    w_p[k*CLA_GROUP +: CLA_GROUP], w_cgrp[k], i);
      end
    end
  endgenerate

  // Each group carry-in is a flat function of group G/P and carry_in only.
  always_comb begin
    logic t_c;
    logic t_p;
    w_cgrp    = '0;
    w_cgrp[0] = carry_in;
    for (int k = 1; k <= NG; k++) begin
      t_c = 1'b0;
      t_p = 1'b1;
      for (int j = k - 1; j >= 0; j--) begin
        t_c = t_c | (t_p & w_gg[j]);
        t_p = t_p & w_gp[j];
      end
      w_cgrp[k] = t_c | (t_p & carry_in);
    end
  end

  assign w_cla_c = w_cgrp[NG];

  rca_core #(
    .WIDTH (WIDTH)
  ) u_rca (
    .a    (a),
    .b    (w_b_eff),
    .cin  (carry_in),
    .sum  (w_rca_y),
    .cout (w_rca_c)
  );

  assign y_d        = w_cla_y;
  assign carry_d    = w_cla_c;
  assign overflow_d = (a[WIDTH-1] == w_b_eff[WIDTH-1]) && (w_cla_y[WIDTH-1] != a[WIDTH-1]);
  assign mismatch_d = (w_cla_y != w_rca_y) || (w_cla_c != w_rca_c);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q        <= '0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      mismatch_q <= 1'b0;
    end else begin
      y_q        <= y_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
      mismatch_q <= mismatch_d;
    end
  end

  assign y        = y_q;
  assign carry    = carry_q;
  assign overflow = overflow_q;
  assign mismatch = mismatch_q;

endmodule

`default_nettype wire

// File: tb/tb_addsub8.sv
// ============================================================
// tb_addsub8 : directed and random checks of addsub8 against an arithmetic model
// rev 1.0
// ============================================================
`default_nettype none

module tb_addsub8;
  import addsub_pkg::*;

  logic  clk;
  logic  rst_n;
  word_t a;
  word_t b;
  logic  carry_in;
  word_t y;
  logic  carry;
  logic  overflow;
  logic  mismatch;

  int checks;
  int errors;

  addsub8 #(
    .WIDTH (ADDSUB_WIDTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .b        (b),
    .carry_in (carry_in),
    .y        (y),
    .carry    (carry),
    .overflow (overflow),
    .mismatch (mismatch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Returns {y, carry, overflow} from plain integer arithmetic.
  function automatic logic [9:0] model(input word_t oa, input word_t ob, input logic sub);
    int ua, ub, sa, sb, r, sr;
    logic c;
    logic [31:0] rv;
    ua = oa;
    ub = ob;
    sa = $signed(oa);
    sb = $signed(ob);
    if (!sub) begin
      r  = ua + ub;
      c  = (r > 255);
      sr = sa + sb;
    end else begin
      r  = ua - ub;
      c  = (ua >= ub);
      sr = sa - sb;
    end
    rv = r;
    return {rv[7:0], c, (sr > 127) || (sr < -128)};
  endfunction

  // Drive between edges, let one rising edge capture, then sample after it.
  task automatic apply(input string tag, input word_t oa, input word_t ob, input logic sub);
    a        = oa;
    b        = ob;
    carry_in = sub;
    @(posedge clk);
    #1;
    chk(tag, {22'd0, y, carry, overflow}, {22'd0, model(oa, ob, sub)});
    chk({tag, "_mis"}, {31'd0, mismatch}, 32'd0);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b1;
    a        = '0;
    b        = '0;
    carry_in = 1'b0;

    #2 rst_n = 1'b0;
    #1;
    chk("reset_outs", {28'd0, y, carry, overflow, mismatch}, 32'd0);
    @(posedge clk);
    #1;
    chk("reset_hold", {28'd0, y, carry, overflow, mismatch}, 32'd0);
    #2 rst_n = 1'b1;

    apply("first_5p5", 8'd5, 8'd5, 1'b0);
    chk("first_y", {24'd0, y}, 32'd10);
    apply("add_8p5", 8'd8, 8'd5, 1'b0);
    chk("add_y", {24'd0, y}, 32'd13);
    apply("sub_8m5", 8'd8, 8'd5, 1'b1);
    chk("sub_c", {31'd0, carry}, 32'd1);
    apply("sub_5m8", 8'd5, 8'd8, 1'b1);
    chk("neg_y", {24'd0, y}, 32'hFD);
    apply("ovf_127p1", 8'd127, 8'd1, 1'b0);
    chk("ovf_add", {24'd0, y, carry, overflow}, {24'd0, 8'h80, 1'b0, 1'b1});
    apply("ovf_80m1", 8'h80, 8'd1, 1'b1);
    chk("ovf_sub", {24'd0, y, carry, overflow}, {24'd0, 8'h7F, 1'b1, 1'b1});
    apply("wrap_ffp1", 8'hFF, 8'd1, 1'b0);
    apply("sub_0m0", 8'd0, 8'd0, 1'b1);
    apply("sub_0m1", 8'd0, 8'd1, 1'b1);

    for (int n = 0; n < 256; n++) begin
      apply(((n & 1) != 0) ? "rnd_sub" : "rnd_add",
            word_t'($urandom_range(0, 255)), word_t'($urandom_range(0, 255)), n[0]);
    end

    // Asynchronous reset dropped mid-cycle during traffic.
    apply("pre_rst", 8'd100, 8'd27, 1'b0);
    a        = 8'd3;
    b        = 8'd4;
    carry_in = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_outs", {28'd0, y, carry, overflow, mismatch}, 32'd0);
    @(posedge clk);
    #1;
    chk("mid_rst_hold", {28'd0, y, carry, overflow, mismatch}, 32'd0);
    a        = 8'd200;
    b        = 8'd56;
    carry_in = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst", {22'd0, y, carry, overflow}, {22'd0, model(8'd200, 8'd56, 1'b0)});
    chk("post_rst_mis", {31'd0, mismatch}, 32'd0);
    apply("post_rst2", 8'd9, 8'd200, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/addsub8.md
Name: addsub8

Overview:
- 8-bit two's-complement adder/subtractor with registered outputs.
- The sum path is a carry-lookahead (CLA) adder.
- A second, independent ripple-carry instance computes the same result in parallel. It is used as a built-in cross-check and flags any disagreement.
- Sits in the datapath as a generic ALU add/sub stage, one clock of latency.

Parameters:
- WIDTH, 8, operand and result width in bits. Must be a multiple of 4, since the CLA is built from 4-bit lookahead groups.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- carry_in  input  1  mode select: 0 = add (a+b), 1 = subtract (a-b)
- y  output  WIDTH  registered result, modulo 2^WIDTH
- carry  output  1  registered raw carry-out of the MSB
- overflow  output  1  registered signed-overflow flag
- mismatch  output  1  registered flag: CLA and ripple results differ

Behaviour:
- Reset: on rst_n low, y, carry, overflow and mismatch clear to 0 immediately, without waiting for clk. They stay 0 while rst_n is low.
- First capture after reset release: on the first rising clk edge with rst_n high.
- Operation:
  - Effective operand is b_eff = b XOR {WIDTH{carry_in}}, with carry_in also used as the LSB carry-in.
  - The internal sum is {carry, y} = a + b_eff + carry_in, computed WIDTH+1 bits wide.
  - Add: carry is the unsigned carry-out.
  - Subtract: carry=1 means no borrow (a >= b unsigned); carry=0 means borrow.
- overflow = (a[MSB] == b_eff[MSB]) && (y[MSB] != a[MSB]), computed on the pre-register values.
- CLA path:
  - Per-bit generate g = a & b_eff and propagate p = a ^ b_eff.
  - 4-bit groups, each producing group G/P.
  - Second-level lookahead across groups; no rippling between groups.
  - Sum bit = p ^ c.
- Ripple path: a chain of WIDTH full adders in the rca_core sub-module, with the same b_eff and carry_in.
- mismatch = (cla_y != rca_y) || (cla_carry != rca_carry). mismatch must be 0 in normal operation.
- Latency and timing:
  - Inputs are sampled on the rising clk edge. Outputs are valid after that same edge, 1-cycle latency.
  - New operands are accepted every cycle; there is no handshake.
- Boundaries:
  - Wrap-around is modulo 2^WIDTH.
  - 127+1 gives y=0x80 and overflow=1.
  - 0x80-1 gives y=0x7F and overflow=1.
- Reset mid-operation: any in-flight result is discarded and the outputs read 0.
- X handling: no special casing; X on inputs may propagate to the outputs.

Decomposition:
- Shared package addsub_pkg holds:
  - localparam ADDSUB_WIDTH = 8
  - localparam CLA_GROUP = 4
  - typedef logic [ADDSUB_WIDTH-1:0] word_t
- One sub-module, rca_core:
  - Parameterised WIDTH ripple-carry adder.
  - Ports: a, b, cin, sum, cout.
  - Instantiated once inside addsub8.
- The CLA logic lives inline in addsub8 as generate loops over the 4-bit groups.

Test Plan:
- Reset: assert rst_n=0 between clk edges -> all outputs 0 immediately; release, a=5, b=5, carry_in=0, one edge -> y=10, carry=0, overflow=0, mismatch=0.
- Add / subtract:
  - a=8, b=5, carry_in=0 -> y=13, carry=0.
  - Next cycle a=8, b=5, carry_in=1 -> y=3, carry=1, overflow=0.
- Negative result: a=5, b=8, carry_in=1 -> y=0xFD (-3), carry=0, overflow=0, mismatch=0.
- Signed overflow:
  - a=127, b=1, carry_in=0 -> y=0x80, carry=0, overflow=1.
  - a=0x80, b=1, carry_in=1 -> y=0x7F, carry=1, overflow=1.
- Back-to-back throughput: change operands every cycle for 256 random pairs in both modes. Each result matches (a±b) mod 256 exactly one cycle later, and mismatch stays 0 throughout.
- Async reset mid-stream: drop rst_n mid-cycle during traffic -> outputs 0 before the next edge; the first result after release corresponds to the operands at the first post-release edge.
